// File: rtl/nn_layer_buf_mem.sv
// Layer activation buffer: self-clearing sweep after reset/clr_req, 1-cycle registered read, sticky range error.
// NN_BUF_ACC_EN enables saturating accumulate-writes via wr_acc; without it every write overwrites.
module nn_layer_buf_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr_req,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_acc,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              oob_err
);

  localparam int                IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_ok, rd_ok;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [DATA_W-1:0] wr_val;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              run_acc;

  // Full-width compare: an address like 0x100A must not alias onto entry 10 mod 2^IDX_W.
  assign wr_ok  = {1'b0, wr_addr} < DEPTH_A;
  assign rd_ok  = {1'b0, rd_addr} < DEPTH_A;
  assign wr_idx = wr_addr[IDX_W-1:0];
  assign rd_idx = rd_addr[IDX_W-1:0];

`ifdef NN_BUF_ACC_EN
  logic [DATA_W-1:0] acc_old;
  logic [DATA_W:0]   acc_sum;
  logic [DATA_W-1:0] acc_sat;

  always_comb begin
    acc_old = mem[wr_idx];
    acc_sum = {acc_old[DATA_W-1], acc_old} + {wr_data[DATA_W-1], wr_data};
    acc_sat = acc_sum[DATA_W-1:0];
    // Sign bits disagree only on overflow; the extra bit holds the true sign.
    if (acc_sum[DATA_W] != acc_sum[DATA_W-1])
      acc_sat = acc_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    wr_val = wr_acc ? acc_sat : wr_data;
  end
`else
  logic unused_wr_acc;
  assign unused_wr_acc = wr_acc;
  assign wr_val        = wr_data;
`endif

  // Accesses only count in RUN and never alongside a clear request.
  assign run_acc = (state_q == S_RUN) && !clr_req;

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    case (state_q)
      S_INIT: begin
        busy      = 1'b1;
        mem_we    = resetn;
        mem_waddr = clr_ptr;
        if (clr_ptr == LAST_IDX) state_d = S_RUN;
      end
      S_RUN: begin
        if (clr_req) begin
          state_d = S_INIT;
        end else if (wr_en && wr_ok) begin
          mem_we    = resetn;
          mem_waddr = wr_idx;
          mem_wdata = wr_val;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_INIT;
      clr_ptr  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      oob_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_valid <= 1'b0;
      if (state_q == S_INIT) begin
        clr_ptr <= (clr_ptr == LAST_IDX) ? '0 : clr_ptr + 1'b1;
      end else if (clr_req) begin
        clr_ptr <= '0;
        oob_err <= 1'b0;
      end
      if (run_acc && rd_en) begin
        rd_valid <= 1'b1;
        rd_data  <= rd_ok ? mem[rd_idx] : '0;
      end
      if (run_acc && ((rd_en && !rd_ok) || (wr_en && !wr_ok)))
        oob_err <= 1'b1;
    end
  end

  // Read above samples the pre-edge contents, giving read-before-write on a shared address.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule
